nec_operand_fetch: RTL and testbench

//  Operand-byte extractor for the decode front-end.

---
 rtl/nec_operand_fetch.sv | 179 +++++++++++++++++
 tb/tb_nec_operand_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nec_operand_fetch.sv
`default_nettype none
// ============================================================================
// nec_operand_fetch : pulls disp/imm bytes from the prefetch queue, advances pc
// Option macro: NEC_OPFETCH_SEXT_EN (sign-extend 1-byte disp/imm on DONE)
// Revision: 1.0
// ============================================================================
module nec_operand_fetch #(
   parameter int IPQ_DEPTH       = 8,
   parameter int BYTES_PER_CYCLE = 1,
   parameter int DISP_MAX        = 2,
   parameter int IMM_MAX         = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ce_1,
   input  logic                          ce_2,
   input  logic                          set_pc,
   input  logic [15:0]                   new_pc,
   input  logic                          start,
   input  logic [2:0]                    disp_size,
   input  logic [2:0]                    imm_size,
   input  logic                          ack,
   input  logic [$clog2(IPQ_DEPTH):0]    ipq_len,
   input  logic [8*IPQ_DEPTH-1:0]        ipq,
   output logic [15:0]                   pc,
   output logic [15:0]                   end_pc,
   output logic [8*DISP_MAX-1:0]         disp,
   output logic [8*IMM_MAX-1:0]          imm,
   output logic                          busy,
   output logic                          done
);

   localparam int AW = $clog2(IPQ_DEPTH);
   localparam int NW = 8;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [NW-1:0] C_DISP_MAX = NW'(DISP_MAX);
   localparam logic [NW-1:0] C_IMM_MAX  = NW'(IMM_MAX);
   localparam logic [NW-1:0] C_BPC      = NW'(BYTES_PER_CYCLE);

   logic [1:0]            state_q, state_d;
   logic [15:0]           pc_q, pc_d, end_pc_q, end_pc_d;
   logic [8*DISP_MAX-1:0] disp_q, disp_d;
   logic [8*IMM_MAX-1:0]  imm_q, imm_d;
   logic [NW-1:0]         disp_len_q, disp_len_d, imm_len_q, imm_len_d;
   logic [NW-1:0]         disp_rd_q, disp_rd_d, imm_rd_q, imm_rd_d;

   logic [NW-1:0]         disp_req, imm_req, rem, n, dr, ir;
   logic [AW-1:0]         idx;
   logic [7:0]            byte_v;
   logic                  take_start;

   always_comb begin
      disp_req = (NW'(disp_size) > C_DISP_MAX) ? C_DISP_MAX : NW'(disp_size);
      imm_req  = (NW'(imm_size)  > C_IMM_MAX)  ? C_IMM_MAX  : NW'(imm_size);
      rem = (disp_len_q - disp_rd_q) + (imm_len_q - imm_rd_q);
      n = C_BPC;
      if (NW'(ipq_len) < n) n = NW'(ipq_len);
      if (rem < n) n = rem;
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      end_pc_d   = end_pc_q;
      disp_d     = disp_q;
      imm_d      = imm_q;
      disp_len_d = disp_len_q;
      imm_len_d  = imm_len_q;
      disp_rd_d  = disp_rd_q;
      imm_rd_d   = imm_rd_q;
      dr         = disp_rd_q;
      ir         = imm_rd_q;
      idx        = '0;
      byte_v     = '0;
      take_start = 1'b0;

      if (set_pc && (ce_1 || ce_2)) begin
         pc_d       = new_pc;
         end_pc_d   = new_pc;
         state_d    = S_IDLE;
         disp_d     = '0;
         imm_d      = '0;
         disp_len_d = '0;
         imm_len_d  = '0;
         disp_rd_d  = '0;
         imm_rd_d   = '0;
      end else if (ce_1) begin
         case (state_q)
            S_IDLE:  take_start = start;
            S_FETCH: begin
               if (n != '0) begin
                  // Bytes fill disp first; the disp/imm boundary may fall mid-cycle.
                  for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
                     if (NW'(k) < n) begin
                        idx = pc_q[AW-1:0] + AW'(k);
                        for (int j = 0; j < IPQ_DEPTH; j++)
                           if (AW'(j) == idx) byte_v = ipq[8*j +: 8];
                        if (dr < disp_len_q) begin
                           for (int j = 0; j < DISP_MAX; j++)
                              if (NW'(j) == dr) disp_d[8*j +: 8] = byte_v;
                           dr = dr + NW'(1);
                        end else begin
                           for (int j = 0; j < IMM_MAX; j++)
                              if (NW'(j) == ir) imm_d[8*j +: 8] = byte_v;
                           ir = ir + NW'(1);
                        end
                     end
                  end
                  disp_rd_d = dr;
                  imm_rd_d  = ir;
                  pc_d      = pc_q + 16'(n);
                  end_pc_d  = pc_q + 16'(n);
                  if (n == rem) begin
                     state_d = S_DONE;
`ifdef NEC_OPFETCH_SEXT_EN
                     if (disp_len_q == NW'(1))
                        for (int j = 1; j < DISP_MAX; j++) disp_d[8*j +: 8] = {8{disp_d[7]}};
                     if (imm_len_q == NW'(1))
                        for (int j = 1; j < IMM_MAX; j++) imm_d[8*j +: 8] = {8{imm_d[7]}};
`endif
                  end
               end
            end
            S_DONE: begin
               if (ack) begin
                  if (start) take_start = 1'b1;
                  else       state_d    = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase

         if (take_start) begin
            disp_len_d = disp_req;
            imm_len_d  = imm_req;
            disp_rd_d  = '0;
            imm_rd_d   = '0;
            disp_d     = '0;
            imm_d      = '0;
            state_d    = ((disp_req == '0) && (imm_req == '0)) ? S_DONE : S_FETCH;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         end_pc_q   <= '0;
         disp_q     <= '0;
         imm_q      <= '0;
         disp_len_q <= '0;
         imm_len_q  <= '0;
         disp_rd_q  <= '0;
         imm_rd_q   <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         end_pc_q   <= end_pc_d;
         disp_q     <= disp_d;
         imm_q      <= imm_d;
         disp_len_q <= disp_len_d;
         imm_len_q  <= imm_len_d;
         disp_rd_q  <= disp_rd_d;
         imm_rd_q   <= imm_rd_d;
      end
   end

   assign pc     = pc_q;
   assign end_pc = end_pc_q;
   assign disp   = disp_q;
   assign imm    = imm_q;
   assign busy   = (state_q == S_FETCH);
   assign done   = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_nec_operand_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_nec_operand_fetch : bench with a 1-byte/cycle and a 4-byte/cycle instance
// Revision: 1.0
// ============================================================================
module tb_nec_operand_fetch;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, ce_1, ce_2, set_pc, start, ack;
   logic [15:0] new_pc;
   logic [2:0]  disp_size, imm_size;
   logic [3:0]  ipq_len;
   logic [63:0] ipq;

   logic [15:0] pc_a, end_pc_a, disp_a, pc_b, end_pc_b, disp_b;
   logic [31:0] imm_a, imm_b;
   logic        busy_a, done_a, busy_b, done_b;

   nec_operand_fetch #(.IPQ_DEPTH(8), .BYTES_PER_CYCLE(1), .DISP_MAX(2), .IMM_MAX(4)) dut_a (
      .clk(clk), .reset(reset), .ce_1(ce_1), .ce_2(ce_2), .set_pc(set_pc), .new_pc(new_pc),
      .start(start), .disp_size(disp_size), .imm_size(imm_size), .ack(ack),
      .ipq_len(ipq_len), .ipq(ipq), .pc(pc_a), .end_pc(end_pc_a), .disp(disp_a),
      .imm(imm_a), .busy(busy_a), .done(done_a));

   nec_operand_fetch #(.IPQ_DEPTH(8), .BYTES_PER_CYCLE(4), .DISP_MAX(2), .IMM_MAX(4)) dut_b (
      .clk(clk), .reset(reset), .ce_1(ce_1), .ce_2(ce_2), .set_pc(set_pc), .new_pc(new_pc),
      .start(start), .disp_size(disp_size), .imm_size(imm_size), .ack(ack),
      .ipq_len(ipq_len), .ipq(ipq), .pc(pc_b), .end_pc(end_pc_b), .disp(disp_b),
      .imm(imm_b), .busy(busy_b), .done(done_b));

   typedef struct {
      logic [15:0] pc0;
      logic [2:0]  dsz;
      logic [2:0]  isz;
      logic [63:0] bytes;
      logic [15:0] disp;
      logic [31:0] imm;
   } vec_t;

   typedef struct {
      int          id;
      logic [15:0] disp;
      logic [31:0] imm;
      logic [15:0] pc;
      int          lat_a;
      int          lat_b;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[8];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ipq(input logic [15:0] p0, input logic [63:0] b);
      for (int k = 0; k < 8; k++)
         ipq[8*((int'(p0) + k) % 8) +: 8] = b[8*k +: 8];
   endtask

   task automatic do_set_pc(input logic [15:0] p);
      set_pc = 1'b1;
      new_pc = p;
      tick();
      set_pc = 1'b0;
   endtask

   task automatic issue(input int id, input vec_t v, input logic with_ack, input logic [3:0] len);
      exp_t e;
      int   dz, iz, total;
      load_ipq(v.pc0, v.bytes);
      disp_size = v.dsz;
      imm_size  = v.isz;
      ipq_len   = len;
      start     = 1'b1;
      ack       = with_ack;
      tick();
      start = 1'b0;
      ack   = 1'b0;
      dz    = (v.dsz > 3'd2) ? 2 : int'(v.dsz);
      iz    = (v.isz > 3'd4) ? 4 : int'(v.isz);
      total = dz + iz;
      e.id   = id;
      e.disp = v.disp;
      e.imm  = v.imm;
`ifdef NEC_OPFETCH_SEXT_EN
      if (dz == 1) e.disp = {{8{v.disp[7]}}, v.disp[7:0]};
      if (iz == 1) e.imm  = {{24{v.imm[7]}}, v.imm[7:0]};
`endif
      e.pc    = v.pc0 + 16'(total);
      e.lat_a = total;
      e.lat_b = (total + 3) / 4;
      sb.push_back(e);
   endtask

   task automatic wait_check(input logic chk_lat);
      exp_t e;
      int   la, lb;
      la = -1;
      lb = -1;
      for (int c = 0; c <= 24; c++) begin
         if (done_a && la < 0) la = c;
         if (done_b && lb < 0) lb = c;
         if (la >= 0 && lb >= 0) break;
         tick();
      end
      e = sb.pop_front();
      chk($sformatf("v%0d done_a", e.id), 64'(done_a), 64'd1);
      chk($sformatf("v%0d done_b", e.id), 64'(done_b), 64'd1);
      if (chk_lat) begin
         chk($sformatf("v%0d latency_a", e.id), 64'(la), 64'(e.lat_a));
         chk($sformatf("v%0d latency_b", e.id), 64'(lb), 64'(e.lat_b));
      end
      chk($sformatf("v%0d disp_a", e.id), 64'(disp_a), 64'(e.disp));
      chk($sformatf("v%0d imm_a", e.id), 64'(imm_a), 64'(e.imm));
      chk($sformatf("v%0d pc_a", e.id), 64'(pc_a), 64'(e.pc));
      chk($sformatf("v%0d end_pc_a", e.id), 64'(end_pc_a), 64'(e.pc));
      chk($sformatf("v%0d disp_b", e.id), 64'(disp_b), 64'(e.disp));
      chk($sformatf("v%0d imm_b", e.id), 64'(imm_b), 64'(e.imm));
      chk($sformatf("v%0d pc_b", e.id), 64'(pc_b), 64'(e.pc));
   endtask

   task automatic ack_idle(input int id);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk($sformatf("v%0d idle done_a", id), 64'(done_a | busy_a), 64'd0);
      chk($sformatf("v%0d idle done_b", id), 64'(done_b | busy_b), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t vx, vy;

      vecs[0] = '{16'h0000, 3'd2, 3'd2, 64'h0000_0000_5678_1234, 16'h1234, 32'h0000_5678};
      vecs[1] = '{16'h0004, 3'd1, 3'd4, 64'h0000_0004_0302_01AA, 16'h00AA, 32'h0403_0201};
      vecs[2] = '{16'h0006, 3'd0, 3'd4, 64'h0000_0000_4433_2211, 16'h0000, 32'h4433_2211};
      vecs[3] = '{16'h0020, 3'd1, 3'd0, 64'h0000_0000_0000_0080, 16'h0080, 32'h0000_0000};
      vecs[4] = '{16'h0030, 3'd0, 3'd1, 64'h0000_0000_0000_00F0, 16'h0000, 32'h0000_00F0};
      vecs[5] = '{16'hFFFE, 3'd7, 3'd7, 64'h0000_0605_0403_0201, 16'h0201, 32'h0605_0403};
      vecs[6] = '{16'h0100, 3'd0, 3'd0, 64'h0000_0000_0000_0000, 16'h0000, 32'h0000_0000};
      vecs[7] = '{16'h0200, 3'd2, 3'd3, 64'h0000_0055_4433_2211, 16'h2211, 32'h0055_4433};

      reset = 1'b1; ce_1 = 1'b0; ce_2 = 1'b0; set_pc = 1'b0; start = 1'b0; ack = 1'b0;
      new_pc = '0; disp_size = '0; imm_size = '0; ipq_len = '0; ipq = '0;
      #2;
      chk("reset pc", 64'(pc_a), 64'd0);
      chk("reset end_pc", 64'(end_pc_a), 64'd0);
      chk("reset disp", 64'(disp_a), 64'd0);
      chk("reset imm", 64'(imm_a), 64'd0);
      chk("reset busy/done", 64'({busy_a, done_a, busy_b, done_b}), 64'd0);
      tick();
      reset = 1'b0;
      ce_1  = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         do_set_pc(vecs[i].pc0);
         chk($sformatf("v%0d set_pc", i), 64'(pc_a), 64'(vecs[i].pc0));
         issue(i, vecs[i], 1'b0, 4'd8);
         wait_check(1'b1);
         ack_idle(i);
      end

      // Back-to-back: start alone in DONE is ignored, ack+start skips IDLE.
      vx = '{16'h0300, 3'd1, 3'd1, 64'h0000_0000_0000_057F, 16'h007F, 32'h0000_0005};
      vy = '{16'h0302, 3'd2, 3'd2, 64'h0000_0000_0403_0201, 16'h0201, 32'h0000_0403};
      do_set_pc(vx.pc0);
      issue(10, vx, 1'b0, 4'd8);
      wait_check(1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start w/o ack ignored done", 64'({done_a, done_b}), 64'b11);
      chk("start w/o ack ignored pc", 64'(pc_a), 64'h0302);
      issue(11, vy, 1'b1, 4'd8);
      chk("b2b busy", 64'({busy_a, busy_b}), 64'b11);
      chk("b2b disp cleared", 64'(disp_a), 64'd0);
      wait_check(1'b1);
      ack_idle(11);

      // Queue starvation then resume.
      vx = '{16'h0040, 3'd2, 3'd2, 64'h0000_0000_0403_0201, 16'h0201, 32'h0000_0403};
      do_set_pc(vx.pc0);
      issue(12, vx, 1'b0, 4'd0);
      for (int s = 0; s < 3; s++) begin
         tick();
         chk($sformatf("starve%0d pc", s), 64'({pc_a, pc_b}), 64'h0040_0040);
         chk($sformatf("starve%0d state", s), 64'({busy_a, done_a, busy_b, done_b}), 64'b1010);
      end
      ipq_len = 4'd2;
      tick();
      chk("resume pc", 64'({pc_a, pc_b}), 64'h0041_0042);
      wait_check(1'b0);
      ack_idle(12);

      // Clock-enable hold, then mid-fetch redirect on ce_2 with start high.
      vx = '{16'h0050, 3'd2, 3'd2, 64'h0000_0000_4433_2211, 16'h2211, 32'h0000_4433};
      do_set_pc(vx.pc0);
      issue(13, vx, 1'b0, 4'd8);
      sb.delete();
      tick();
      ce_1 = 1'b0;
      for (int s = 0; s < 3; s++) tick();
      chk("ce hold pc", 64'(pc_a), 64'h0051);
      chk("ce hold disp", 64'(disp_a), 64'h0011);
      chk("ce hold busy", 64'(busy_a), 64'd1);
      ce_2   = 1'b1;
      set_pc = 1'b1;
      new_pc = 16'h1000;
      start  = 1'b1;
      tick();
      ce_2 = 1'b0; set_pc = 1'b0; start = 1'b0; ce_1 = 1'b1;
      chk("redirect pc", 64'({pc_a, pc_b}), 64'h1000_1000);
      chk("redirect end_pc", 64'({end_pc_a, end_pc_b}), 64'h1000_1000);
      chk("redirect state", 64'({busy_a, done_a, busy_b, done_b}), 64'd0);
      chk("redirect disp/imm", 64'({disp_a, disp_b, imm_b}), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
